// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-port synchronous RAM.
// Handles sub-word stores, sign/zero-extended loads, and split reads for word-crossing loads.
module load_store_unit #(
    parameter int unsigned CROSS_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [1:0]  mem_ctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] STORE_B  = 2'b00;
    localparam logic [1:0] STORE_HW = 2'b01;
    localparam logic [1:0] STORE_W  = 2'b10;
    localparam logic       CROSS    = (CROSS_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAP_LO,
        CAP_HI,
        STORE,
        RESP
    } state_t;

    state_t      state, state_n;
    logic [2:0]  op_f3, op_f3_n;
    logic [1:0]  op_off, op_off_n;
    logic        op_cross, op_cross_n;
    logic [31:0] word_lo, word_lo_n;

    logic        mem_we_n;
    logic [1:0]  mem_ctrl_n;
    logic [31:0] mem_addr_n;
    logic [31:0] mem_wdata_n;
    logic        resp_valid_n;
    logic [31:0] resp_rdata_n;
    logic        resp_err_n;

    logic [1:0]  req_off;
    logic        store_ok;
    logic        load_ok;
    logic        load_cross;

    // {hi,lo} shifted by the byte offset, then truncated and extended per funct3.
    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        logic [63:0] sh;
        sh = {hi, lo} >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
            3'b100:  extract = {24'h000000, sh[7:0]};
            3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
            3'b101:  extract = {16'h0000, sh[15:0]};
            default: extract = sh[31:0];
        endcase
    endfunction

    assign req_off  = req_addr[1:0];
    assign store_ok = (req_funct3 == 3'b000)
                   || (req_funct3 == 3'b001 && req_off != 2'd3)
                   || (req_funct3 == 3'b010 && req_off == 2'd0);
    assign load_ok  = (req_funct3 == 3'b000) || (req_funct3 == 3'b001)
                   || (req_funct3 == 3'b010) || (req_funct3 == 3'b100)
                   || (req_funct3 == 3'b101);
    assign load_cross = ((req_funct3[1:0] == 2'b01) && req_off == 2'd3)
                     || ((req_funct3 == 3'b010) && req_off != 2'd0);

    // Ready is decoded from the state flop and forced low while reset is held.
    assign req_ready = (state == IDLE) && !rst;

    always_comb begin
        state_n      = state;
        op_f3_n      = op_f3;
        op_off_n     = op_off;
        op_cross_n   = op_cross;
        word_lo_n    = word_lo;
        mem_we_n     = 1'b0;
        mem_ctrl_n   = mem_ctrl;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        resp_valid_n = 1'b0;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_f3_n  = req_funct3;
                    op_off_n = req_off;
                    if (req_we) begin
                        if (store_ok) begin
                            state_n     = STORE;
                            mem_we_n    = 1'b1;
                            mem_addr_n  = req_addr;
                            mem_wdata_n = req_wdata;
                            case (req_funct3[1:0])
                                2'b00:   mem_ctrl_n = STORE_B;
                                2'b01:   mem_ctrl_n = STORE_HW;
                                default: mem_ctrl_n = STORE_W;
                            endcase
                        end else begin
                            state_n      = RESP;
                            resp_valid_n = 1'b1;
                            resp_err_n   = 1'b1;
                            resp_rdata_n = '0;
                        end
                    end else if (load_ok) begin
                        state_n    = ISSUE;
                        mem_addr_n = {req_addr[31:2], 2'b00};
                        op_cross_n = load_cross;
                    end else begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                    end
                end
            end
            ISSUE: begin
                state_n = CAP_LO;
                // Next word address is presented during CAP_LO; wraps past 0xFFFFFFFC.
                if (op_cross && CROSS) begin
                    mem_addr_n = mem_addr + 32'd4;
                end
            end
            CAP_LO: begin
                word_lo_n = mem_rdata;
                if (op_cross) begin
                    if (CROSS) begin
                        state_n = CAP_HI;
                    end else begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                    end
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b0;
                    resp_rdata_n = extract(op_f3, op_off, mem_rdata, '0);
                end
            end
            CAP_HI: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_err_n   = 1'b0;
                resp_rdata_n = extract(op_f3, op_off, word_lo, mem_rdata);
            end
            STORE: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_err_n   = 1'b0;
                resp_rdata_n = '0;
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_f3      <= '0;
            op_off     <= '0;
            op_cross   <= 1'b0;
            word_lo    <= '0;
            mem_we     <= 1'b0;
            mem_ctrl   <= STORE_W;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_n;
            op_f3      <= op_f3_n;
            op_off     <= op_off_n;
            op_cross   <= op_cross_n;
            word_lo    <= word_lo_n;
            mem_we     <= mem_we_n;
            mem_ctrl   <= mem_ctrl_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
        end
    end

endmodule
